cam_capture_ctrl: RTL
=====================

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter FRAME_W, 8, width of the frame-request and frame counters.
REQ-002 Parameter PKT_W, 16, width of the packet counter.
REQ-003 Parameter TIMEOUT_CYC, 24'd1000000, watchdog limit in clk cycles.
REQ-004 Port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, one-cycle capture request.
REQ-007 Port stop, input, 1, one-cycle cancel request.
REQ-008 Port frames_req, input, FRAME_W, frames to capture per start; 0 = continuous.
REQ-009 Port cam_vsync, input, 1, camera vsync already synchronised to clk; high between frames.
REQ-010 Port pkt_done, input, 1, one-cycle pulse per completed packet (rx ram switch).
REQ-011 Port ram_lost, input, 1, one-cycle pulse when a packet switch failed.
REQ-012 Port capture_en, output, 1, enables the cam rx datapath.
REQ-013 Port abort, output, 1, one-cycle pulse that cleans rx ram and rx state.
REQ-014 Port busy, output, 1, high in any state other than IDLE.
REQ-015 Port done, output, 1, one-cycle pulse when the requested frames have been captured.
REQ-016 Port err, output, 1, sticky watchdog-timeout flag.
REQ-017 Port frame_cnt, output, FRAME_W, frames completed since the last accepted start.
REQ-018 Port pkt_cnt, output, PKT_W, packets completed since the last accepted start.
REQ-019 Port lost_cnt, output, 8, packets lost since the last accepted start.

Function
REQ-020 The FSM SHALL have the states IDLE, ARM, CAPTURE, FINISH and ABORT, encoded 0 to 4.
REQ-021 cam_vsync SHALL be registered once (vsync_d); fall = vsync_d & ~cam_vsync; rise = ~vsync_d & cam_vsync.
REQ-022 IDLE: start with stop low SHALL clear frame_cnt, pkt_cnt, lost_cnt and err, then enter ARM; start together with stop SHALL be ignored.
REQ-023 ARM: fall SHALL enter CAPTURE.
REQ-024 CAPTURE: rise SHALL increment frame_cnt; if frames_req != 0 and the new count equals frames_req, the FSM SHALL enter FINISH, otherwise ARM.
REQ-025 FINISH SHALL last one cycle, assert done for that cycle, then enter IDLE.
REQ-026 stop in ARM or CAPTURE SHALL enter ABORT; stop SHALL take priority over a vsync edge in the same cycle.
REQ-027 ABORT SHALL last one cycle, assert abort for that cycle, then enter IDLE.
REQ-028 capture_en SHALL be registered and high exactly while the state is CAPTURE, i.e. it rises in the cycle after the cycle in which the FSM decodes fall.
REQ-029 pkt_cnt SHALL increment on pkt_done only while the state is CAPTURE, and SHALL saturate at all-ones.
REQ-030 lost_cnt SHALL increment on ram_lost in any non-IDLE state, and SHALL saturate at 255.
REQ-031 frame_cnt SHALL wrap modulo 2^FRAME_W in continuous mode.
REQ-032 start received while busy SHALL be ignored.
REQ-033 frames_req SHALL be sampled live at each rise; software changes it only while the block is idle.

Reset
REQ-034 Reset SHALL force the state to IDLE, clear vsync_d and the watchdog, and drive all outputs and counters to 0.
REQ-035 Reset asserted mid-capture SHALL drop capture_en asynchronously and SHALL NOT produce an abort pulse or a done pulse.

Configuration
REQ-036 Macro CAM_CAPTURE_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-037 With the macro defined: a cycle counter SHALL clear on entry to ARM or CAPTURE and on every vsync edge; when it reaches TIMEOUT_CYC in ARM or CAPTURE, err SHALL set and the FSM SHALL enter ABORT.
REQ-038 stop SHALL have priority over the timeout in the same cycle.
REQ-039 Without the macro: no counter SHALL be built, err SHALL be tied to 0, and ARM/CAPTURE SHALL wait indefinitely.

Verification
REQ-040 frames_req=2, start, then 2 vsync frames with 3 pkt_done each -> done pulse once, frame_cnt=2, pkt_cnt=6, busy low the cycle after done.
REQ-041 frames_req=0, 300 frames -> never done, frame_cnt=44 (wrapped), capture_en toggles every frame.
REQ-042 stop in the same cycle as a vsync rise during CAPTURE -> abort pulse for 1 cycle, frame_cnt unchanged, no done pulse.
REQ-043 Macro defined, TIMEOUT_CYC=100, vsync held high after start -> err=1 and abort pulse at cycle 100 after ARM entry; next start clears err.
REQ-044 Reset asserted during CAPTURE with pkt_cnt=5 -> capture_en=0 immediately, all counters 0, no abort or done pulse.
REQ-045 ram_lost pulsed 260 times while busy -> lost_cnt=255; pkt_done pulses during ARM -> pkt_cnt unchanged.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: arms on start, captures frames between vsync edges, counts packets/losses.
// Optional watchdog compiled in with `define CAM_CAPTURE_TIMEOUT_EN.
module cam_capture_ctrl #(
  parameter int unsigned FRAME_W     = 8,
  parameter int unsigned PKT_W       = 16,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [FRAME_W-1:0] frames_req,
  input  logic               cam_vsync,
  input  logic               pkt_done,
  input  logic               ram_lost,
  output logic               capture_en,
  output logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [PKT_W-1:0]   pkt_cnt,
  output logic [7:0]         lost_cnt,
  output logic [2:0]         state_dbg
);

  // Handshake: start/stop/pkt_done/ram_lost are single-cycle strobes sampled on
  // the rising edge; done/abort are single-cycle strobes with no ready return.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_FINISH  = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               vsync_d;
  logic               fall;
  logic               rise;
  logic               timeout;
  logic               start_ok;
  logic               in_wait;
  logic               frame_inc;
  logic [FRAME_W-1:0] frame_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= cam_vsync;
  end

  assign fall       = vsync_d & ~cam_vsync;
  assign rise       = ~vsync_d & cam_vsync;
  assign in_wait    = (state == S_ARM) || (state == S_CAPTURE);
  assign start_ok   = (state == S_IDLE) & start & ~stop;
  assign frame_next = frame_cnt + FRAME_W'(1);
  // stop outranks the watchdog, which outranks a vsync edge
  assign frame_inc  = (state == S_CAPTURE) & rise & ~stop & ~timeout;

`ifdef CAM_CAPTURE_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        wd_clr;

  assign wd_clr  = rise | fall |
                   ((state_next != state) &&
                    ((state_next == S_ARM) || (state_next == S_CAPTURE)));
  // wd_cnt equals the number of cycles already spent waiting, so the abort
  // lands exactly TIMEOUT_CYC cycles after the wait began.
  assign timeout = in_wait & (wd_cnt >= (TIMEOUT_CYC - 24'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wd_cnt <= 24'd0;
    else if (wd_clr || !in_wait) wd_cnt <= 24'd0;
    else                         wd_cnt <= wd_cnt + 24'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                err <= 1'b0;
    else if (start_ok)        err <= 1'b0;
    else if (timeout && !stop) err <= 1'b1;
  end
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_next = S_ARM;
      end
      S_ARM: begin
        if (stop || timeout) state_next = S_ABORT;
        else if (fall)       state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (stop || timeout) state_next = S_ABORT;
        else if (rise) begin
          if ((frames_req != '0) && (frame_next == frames_req)) state_next = S_FINISH;
          else                                                   state_next = S_ARM;
        end
      end
      S_FINISH: state_next = S_IDLE;
      S_ABORT:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    state_dbg = state;
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    abort     = (state == S_ABORT);
  end

  // Registered from the next state so it tracks CAPTURE without a decode lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) capture_en <= 1'b0;
    else       capture_en <= (state_next == S_CAPTURE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          frame_cnt <= '0;
    else if (start_ok)  frame_cnt <= '0;
    else if (frame_inc) frame_cnt <= frame_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pkt_cnt <= '0;
    else if (start_ok) pkt_cnt <= '0;
    else if ((state == S_CAPTURE) && pkt_done && (pkt_cnt != '1))
      pkt_cnt <= pkt_cnt + PKT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         lost_cnt <= 8'd0;
    else if (start_ok) lost_cnt <= 8'd0;
    else if ((state != S_IDLE) && ram_lost && (lost_cnt != 8'hFF))
      lost_cnt <= lost_cnt + 8'd1;
  end

endmodule
